// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// Holds the memory-wait FSM state encoding, forwarding selects and counter width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } wait_state_t;

  localparam int CNT_W = 4;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait sequencer: stalls the pipe for exactly MEM_WAIT_CYCLES per access.
// Latency: stall asserts in the same cycle mem_req is seen in IDLE; no backpressure.
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic stall,
  output logic mem_busy
);

  wait_state_t          state;
  logic [CNT_W-1:0]     cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            if (MEM_WAIT_CYCLES > 1) begin
              cnt   <= CNT_W'(MEM_WAIT_CYCLES - 1);
              state <= BUSY;
            end else begin
              state <= DONE;
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) state <= DONE;
          else                  cnt   <= cnt - CNT_W'(1);
        end
        // The departing instruction still drives mem_req here; it must not restart a wait.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall    = rst && (((state == IDLE) && mem_req) || (state == BUSY));
  assign mem_busy = rst && (state != IDLE);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: freeze/flush sequencing, RAW hazards, branch flush, memory stall.
// Latency: all outputs combinational, zero cycles; FORWARDING_EN adds EXE operand forwarding selects.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_src1_used,
  input  logic       id_src2_used,
  input  logic [3:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_r_en,
  input  logic [3:0] mem_dest,
  input  logic       mem_wb_en,
  input  logic [3:0] wb_dest,
  input  logic       wb_wb_en,
  input  logic       exe_branch_taken,
  input  logic       mem_req,
  output logic       freeze_if,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       freeze_back,
`ifdef FORWARDING_EN
  output logic [1:0] fwd_sel_a,
  output logic [1:0] fwd_sel_b,
`endif
  output logic       mem_busy
);

  logic stall;
  logic hz_exe;
  logic hz_mem;
  logic hazard;

  mem_wait_fsm #(
    .MEM_WAIT_CYCLES (MEM_WAIT_CYCLES)
  ) u_mem_wait_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .stall    (stall),
    .mem_busy (mem_busy)
  );

  assign hz_exe = exe_wb_en && ((id_src1_used && (id_src1 == exe_dest)) ||
                                (id_src2_used && (id_src2 == exe_dest)));
  assign hz_mem = mem_wb_en && ((id_src1_used && (id_src1 == mem_dest)) ||
                                (id_src2_used && (id_src2 == mem_dest)));

`ifdef FORWARDING_EN
  // With forwarding only a load in EXE cannot be bypassed in time.
  assign hazard = exe_mem_r_en && hz_exe;

  logic unused_hz;
  assign unused_hz = hz_mem;

  always_comb begin
    fwd_sel_a = FWD_REG;
    fwd_sel_b = FWD_REG;
    if (rst) begin
      if (mem_wb_en && (id_src1 == mem_dest))     fwd_sel_a = FWD_MEM;
      else if (wb_wb_en && (id_src1 == wb_dest))  fwd_sel_a = FWD_WB;
      if (mem_wb_en && (id_src2 == mem_dest))     fwd_sel_b = FWD_MEM;
      else if (wb_wb_en && (id_src2 == wb_dest))  fwd_sel_b = FWD_WB;
    end
  end
`else
  assign hazard = hz_exe || hz_mem;

  logic unused_fwd;
  assign unused_fwd = ^{wb_dest, wb_wb_en, exe_mem_r_en};
`endif

  always_comb begin
    freeze_if   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    freeze_back = 1'b0;
    if (!rst) begin
      freeze_if = 1'b0;
    end else if (stall) begin
      // A taken branch waits in the frozen EXE and is flushed once stall drops.
      freeze_if   = 1'b1;
      freeze_back = 1'b1;
    end else if (exe_branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hazard) begin
      freeze_if   = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes expected outputs, a negedge monitor pops and compares.
// Control vector order: {freeze_if, flush_if_id, flush_id_ex, freeze_back, mem_busy}.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest, wb_dest;
  logic       id_src1_used, id_src2_used, exe_wb_en, exe_mem_r_en;
  logic       mem_wb_en, wb_wb_en, exe_branch_taken, mem_req;
  logic       freeze_if, flush_if_id, flush_id_ex, freeze_back, mem_busy;
  logic [1:0] fwd_sel_a, fwd_sel_b;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_WAIT_CYCLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_src1          (id_src1),
    .id_src2          (id_src2),
    .id_src1_used     (id_src1_used),
    .id_src2_used     (id_src2_used),
    .exe_dest         (exe_dest),
    .exe_wb_en        (exe_wb_en),
    .exe_mem_r_en     (exe_mem_r_en),
    .mem_dest         (mem_dest),
    .mem_wb_en        (mem_wb_en),
    .wb_dest          (wb_dest),
    .wb_wb_en         (wb_wb_en),
    .exe_branch_taken (exe_branch_taken),
    .mem_req          (mem_req),
    .freeze_if        (freeze_if),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .freeze_back      (freeze_back),
`ifdef FORWARDING_EN
    .fwd_sel_a        (fwd_sel_a),
    .fwd_sel_b        (fwd_sel_b),
`endif
    .mem_busy         (mem_busy)
  );

`ifndef FORWARDING_EN
  assign fwd_sel_a = 2'b00;
  assign fwd_sel_b = 2'b00;
`endif

  typedef struct {
    string      name;
    logic [4:0] ctrl;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [4:0] C_NONE   = 5'b00000;
  localparam logic [4:0] C_STALL0 = 5'b10010;
  localparam logic [4:0] C_STALL  = 5'b10011;
  localparam logic [4:0] C_DONE   = 5'b00001;
  localparam logic [4:0] C_HAZ    = 5'b10100;
  localparam logic [4:0] C_BR     = 5'b01100;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e   = q.pop_front();
      act = {freeze_if, flush_if_id, flush_id_ex, freeze_back, mem_busy};
      n_cmp++;
      if (act !== e.ctrl) begin
        n_bad++;
        $display("FAIL %s: ctrl got %b want %b", e.name, act, e.ctrl);
      end
`ifdef FORWARDING_EN
      n_cmp++;
      if ({fwd_sel_a, fwd_sel_b} !== {e.fa, e.fb}) begin
        n_bad++;
        $display("FAIL %s: fwd a/b got %b/%b want %b/%b", e.name, fwd_sel_a, fwd_sel_b, e.fa, e.fb);
      end
`endif
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input logic [4:0] c,
                            input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00);
    exp_t e;
    e.name = n; e.ctrl = c; e.fa = fa; e.fb = fb;
    q.push_back(e);
  endtask

  task automatic clr();
    id_src1 = 0; id_src2 = 0; id_src1_used = 0; id_src2_used = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0; wb_dest = 0; wb_wb_en = 0;
    exe_branch_taken = 0; mem_req = 0;
  endtask

  initial begin
    clr();
    rst = 1'b0;
    // Reset forces everything low even with a request and a hazard pending.
    go();
    mem_req = 1; id_src1 = 3; id_src1_used = 1; exe_dest = 3; exe_wb_en = 1;
    expect_out("reset_forced", C_NONE);
    go(); clr(); rst = 1'b1;
    expect_out("post_reset_idle", C_NONE);

    // Single access: 4 stall cycles, DONE ignores the lingering request, then IDLE.
    go(); mem_req = 1; expect_out("single_s0", C_STALL0);
    for (int i = 0; i < 3; i++) begin go(); expect_out("single_busy", C_STALL); end
    go(); expect_out("single_done", C_DONE);
    go(); mem_req = 0; expect_out("single_idle", C_NONE);

    // Back-to-back: 4 stall, 1 free, 4 stall.
    go(); mem_req = 1; expect_out("b2b_a_s0", C_STALL0);
    for (int i = 0; i < 3; i++) begin go(); expect_out("b2b_a_busy", C_STALL); end
    go(); expect_out("b2b_done_a", C_DONE);
    go(); expect_out("b2b_b_s0", C_STALL0);
    for (int i = 0; i < 3; i++) begin go(); expect_out("b2b_b_busy", C_STALL); end
    go(); expect_out("b2b_done_b", C_DONE);
    go(); mem_req = 0; expect_out("b2b_idle", C_NONE);

    // RAW against EXE, then with a taken branch overriding it.
    go(); clr(); id_src1 = 3; id_src1_used = 1; exe_dest = 3; exe_wb_en = 1;
`ifdef FORWARDING_EN
    expect_out("hz_exe_alu", C_NONE);
`else
    expect_out("hz_exe", C_HAZ);
`endif
    go(); exe_branch_taken = 1; expect_out("branch_over_hz", C_BR);
    go(); clr(); id_src1 = 3; id_src1_used = 0; exe_dest = 3; exe_wb_en = 1;
    expect_out("unused_src", C_NONE);
    go(); clr(); id_src1 = 3; id_src1_used = 1; exe_dest = 4'd11; exe_wb_en = 1;
    expect_out("bit3_differs", C_NONE);
    go(); clr(); id_src2 = 3; id_src2_used = 1; exe_dest = 3; exe_wb_en = 0;
    expect_out("exe_no_wb", C_NONE);

    // RAW against MEM; R15 compared like any register.
    go(); clr(); id_src2 = 7; id_src2_used = 1; mem_dest = 7; mem_wb_en = 1;
`ifdef FORWARDING_EN
    expect_out("hz_mem_fwd", C_NONE, 2'b00, 2'b01);
`else
    expect_out("hz_mem", C_HAZ);
`endif
    go(); clr(); id_src1 = 15; id_src1_used = 1; exe_dest = 15; exe_wb_en = 1; exe_mem_r_en = 1;
    expect_out("r15_load", C_HAZ);

`ifdef FORWARDING_EN
    go(); clr(); id_src2 = 5; id_src2_used = 1; mem_dest = 5; mem_wb_en = 1; wb_dest = 5; wb_wb_en = 1;
    expect_out("fwd_mem_prio", C_NONE, 2'b00, 2'b01);
    go(); mem_wb_en = 0; expect_out("fwd_wb", C_NONE, 2'b00, 2'b10);
    go(); clr(); id_src2 = 5; id_src2_used = 1; exe_dest = 5; exe_wb_en = 1; exe_mem_r_en = 1;
    expect_out("load_use", C_HAZ);
    go(); clr(); id_src2 = 5; id_src2_used = 1; mem_dest = 5; mem_wb_en = 1;
    expect_out("load_fwd", C_NONE, 2'b00, 2'b01);
`endif

    // Branch held under stall is flushed only when stall drops.
    go(); clr(); mem_req = 1; exe_branch_taken = 1; expect_out("br_stall_s0", C_STALL0);
    for (int i = 0; i < 3; i++) begin go(); expect_out("br_stall_busy", C_STALL); end
    go(); expect_out("br_at_done", C_BR | C_DONE);
    go(); clr(); expect_out("br_clear", C_NONE);

    // Reset in BUSY with cnt==2 aborts; release with mem_req restarts a full wait.
    go(); mem_req = 1; expect_out("rst_s0", C_STALL0);
    go(); expect_out("rst_busy3", C_STALL);
    go(); rst = 1'b0; expect_out("rst_abort", C_NONE);
    go(); expect_out("rst_held", C_NONE);
    go(); rst = 1'b1; expect_out("rst_restart_s0", C_STALL0);
    for (int i = 0; i < 3; i++) begin go(); expect_out("rst_restart_busy", C_STALL); end
    go(); expect_out("rst_restart_done", C_DONE);
    go(); mem_req = 0; expect_out("rst_restart_idle", C_NONE);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

- Central pipeline controller for the five-stage ARM core.
- Generates per-stage freeze and flush controls that sequence the IF/ID and ID/EX stage registers; the ID/EX flush inserts a zeroed bubble.
- Detects RAW hazards against the EXE and MEM destinations, flushes on taken branches, and stalls the whole pipe for the fixed data-memory wait.
- Optionally produces forwarding selects for the EXE operand muxes.

## Interface
- MEM_WAIT_CYCLES, 4, stall cycles per data-memory access; legal range 1..15.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset; asserted when 0.
- id_src1, id_src2  in  4 each  Rn / Rm (or Rd for STR) indices decoded in ID.
- id_src1_used, id_src2_used  in  1 each  the operand is actually read.
- exe_dest  in  4  destination of the instruction in EXE.
- exe_wb_en  in  1  write-back enable of the instruction in EXE.
- exe_mem_r_en  in  1  the instruction in EXE is a load.
- mem_dest  in  4  destination of the instruction in MEM.
- mem_wb_en  in  1  write-back enable of the instruction in MEM.
- wb_dest  in  4  destination of the instruction in WB.
- wb_wb_en  in  1  write-back enable of the instruction in WB.
- exe_branch_taken  in  1  B resolved taken in EXE.
- mem_req  in  1  instruction in MEM has MEM_R_EN or MEM_W_EN set.
- freeze_if  out  1  hold PC and IF/ID.
- flush_if_id  out  1  zero IF/ID at the next edge.
- flush_id_ex  out  1  zero ID/EX at the next edge (bubble).
- freeze_back  out  1  hold ID/EX, EXE/MEM and MEM/WB.
- mem_busy  out  1  memory wait FSM not IDLE.
- fwd_sel_a, fwd_sel_b  out  2 each  operand source: 00 register file, 01 MEM result, 10 WB result. Present only with FORWARDING_EN.

## Operation
- Memory wait FSM, states IDLE, BUSY, DONE, with a 4-bit down-counter cnt.
  - IDLE with mem_req: stall=1. If MEM_WAIT_CYCLES>1, load cnt=MEM_WAIT_CYCLES-1 and go to BUSY; otherwise go to DONE.
  - IDLE without mem_req: stall=0; stay in IDLE.
  - BUSY: stall=1. If cnt==1, go to DONE; otherwise decrement cnt.
  - DONE: stall=0; mem_req is ignored (it still shows the departing instruction); always go to IDLE.
  - Result: exactly MEM_WAIT_CYCLES stall cycles per access. Back-to-back memory instructions each get a full wait.
- Hazard detection:
  - hz_exe = exe_wb_en and a used source equals exe_dest.
  - hz_mem = mem_wb_en and a used source equals mem_dest.
- Output priority, highest first:
  1. stall: freeze_if=1, freeze_back=1, both flushes 0. A branch held in a frozen EXE is acted on once stall drops.
  2. exe_branch_taken: flush_if_id=1, flush_id_ex=1, freeze_if=0. The branch overrides any hazard.
  3. Hazard: freeze_if=1, flush_id_ex=1, flush_if_id=0.
  4. Otherwise all outputs 0.
- mem_busy = (state != IDLE).

## Timing
- The FSM is the only sequential state (state and cnt). All other outputs are combinational from the current state and inputs, zero latency.
- Reset: state=IDLE, cnt=0. While rst==0, every output is forced to 0.
- Reset asserted mid-wait aborts the access immediately. After release the FSM is in IDLE and a still-asserted mem_req starts a fresh full wait.
- Register-index comparisons are on the full 4 bits. R15 is compared like any other register.

## Configuration
- FORWARDING_EN defined:
  - fwd_sel_a and fwd_sel_b exist. For each source: MEM match (mem_wb_en) gives 01, else WB match (wb_wb_en) gives 10, else 00. MEM has priority over WB.
  - The hazard condition reduces to load-use only: exe_mem_r_en and hz_exe.
- FORWARDING_EN undefined:
  - fwd_sel_a and fwd_sel_b are absent.
  - Hazard = hz_exe or hz_mem.

## Structure
- Package pipe_ctrl_pkg holds:
  - the FSM state enum (IDLE, BUSY, DONE);
  - the forwarding select constants FWD_REG, FWD_MEM, FWD_WB;
  - the counter width constant.
- One sub-module, mem_wait_fsm: holds state and cnt and outputs stall and mem_busy. The hazard, branch and forwarding logic stay in the top level.

## Test plan
- MEM_WAIT_CYCLES=4, single-cycle mem_req pulse held for the access → stall (freeze_back=1) for exactly 4 cycles, then a DONE cycle with stall 0, then IDLE.
- Two consecutive memory instructions → 4 stall cycles, 1 free cycle, 4 stall cycles.
- Non-forwarding build: id_src1=3, id_src1_used=1, exe_dest=3, exe_wb_en=1 → freeze_if=1, flush_id_ex=1. Adding exe_branch_taken=1 → flush_if_id=1, freeze_if=0.
- FORWARDING_EN build: mem_dest=5 and wb_dest=5, both write-enabled, id_src2=5 → fwd_sel_b=01, no stall. Load in EXE with exe_dest=5 → one-cycle bubble.
- rst=0 during BUSY with cnt=2 → all outputs 0 immediately. After release with mem_req=1 → full 4-cycle stall.
- Branch taken while stall=1 → no flush until the cycle stall drops, then both flushes assert.
